// File: rtl/sub32_seq.sv
// Digit-serial 32-bit subtractor: DIGIT_W bits per RUN cycle, LSB first, borrow chained.
// Optional signed-overflow output is built only when SUB32_OVF_EN is defined.
module sub32_seq #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout
`ifdef SUB32_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned N     = 32 / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW1   = DIGIT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_borrow;
  logic [31:0]        r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [DW1-1:0]     w_dig;
  logic [31:0]        w_acc_next;
`ifdef SUB32_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start is only honoured in IDLE and DONE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(N - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One digit of subtraction; the top bit of the (DIGIT_W+1)-bit result is the borrow
  assign w_dig = {1'b0, r_a[DIGIT_W-1:0]} - {1'b0, r_b[DIGIT_W-1:0]} - DW1'(r_borrow);

  generate
    if (DIGIT_W == 32) begin : g_full
      assign w_acc_next = w_dig[31:0];
    end else begin : g_part
      assign w_acc_next = {w_dig[DIGIT_W-1:0], r_acc[31:DIGIT_W]};
    end
  endgenerate

  // Operand shifters, partial result and digit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
`ifdef SUB32_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
`ifdef SUB32_OVF_EN
      r_a_msb  <= a[31];
      r_b_msb  <= b[31];
`endif
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> DIGIT_W;
      r_b      <= r_b >> DIGIT_W;
      r_borrow <= w_dig[DIGIT_W];
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Visible result changes only on the final digit, so partial sums never leak out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB32_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (w_last) begin
      diff <= w_acc_next;
      bout <= w_dig[DIGIT_W];
`ifdef SUB32_OVF_EN
      ovf  <= (r_a_msb != r_b_msb) && (w_acc_next[31] != r_a_msb);
`endif
    end
  end

  // Status flags registered from the next state so they align with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (w_next != S_RUN);
      busy  <= (w_next == S_RUN);
      done  <= (w_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_sub32_seq.sv
// Scoreboard bench for sub32_seq: DIGIT_W=1 and DIGIT_W=8 instances, optional ovf under SUB32_OVF_EN.
module tb_sub32_seq;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q1[$];
  exp_t        q8[$];

  logic        s1_start, s1_bin, s8_start, s8_bin;
  logic [31:0] s1_a, s1_b, s8_a, s8_b;
  logic        o1_ready, o1_busy, o1_done, o1_bout;
  logic        o8_ready, o8_busy, o8_done, o8_bout;
  logic [31:0] o1_diff, o8_diff;
`ifdef SUB32_OVF_EN
  logic        o1_ovf, o8_ovf;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub32_seq #(.DIGIT_W(1)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
    .ready(o1_ready), .busy(o1_busy), .done(o1_done), .diff(o1_diff), .bout(o1_bout)
`ifdef SUB32_OVF_EN
    , .ovf(o1_ovf)
`endif
  );

  sub32_seq #(.DIGIT_W(8)) u8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .bin(s8_bin),
    .ready(o8_ready), .busy(o8_busy), .done(o8_done), .diff(o8_diff), .bout(o8_bout)
`ifdef SUB32_OVF_EN
    , .ovf(o8_ovf)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks result and latency
  always @(negedge clk) begin
    exp_t e;
    if (o1_done === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q1.pop_front();
        check("u1_diff", 64'(o1_diff), 64'(e.d));
        check("u1_bout", 64'(o1_bout), 64'(e.bo));
        check("u1_latency", 64'(cyc), 64'(e.cyc));
`ifdef SUB32_OVF_EN
        check("u1_ovf", 64'(o1_ovf), 64'(e.ov));
`endif
      end
    end
    if (o8_done === 1'b1) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL u8_spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q8.pop_front();
        check("u8_diff", 64'(o8_diff), 64'(e.d));
        check("u8_bout", 64'(o8_bout), 64'(e.bo));
        check("u8_latency", 64'(cyc), 64'(e.cyc));
`ifdef SUB32_OVF_EN
        check("u8_ovf", 64'(o8_ovf), 64'(e.ov));
`endif
      end
    end
  end

  // Issue one op on u1 (call #1 after a posedge with u1 ready); operands scrambled afterwards
  task automatic op1(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                     input logic [31:0] ed, input logic eb, input logic eo, input bit push);
    exp_t e;
    s1_a = ta; s1_b = tb; s1_bin = tbin; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    s1_a = $urandom; s1_b = $urandom; s1_bin = 1'($urandom);
    e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + 32;
    if (push) q1.push_back(e);
  endtask

  task automatic wait1();
    repeat (33) @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [31:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + 4;
    q8.push_back(e);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rbin;
    logic [32:0] sum;
    logic [31:0] md;

    rst = 1'b1;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_bin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 64'(o1_ready), 64'(1));
    check("rst_busy", 64'(o1_busy), 64'(0));
    check("rst_done", 64'(o1_done), 64'(0));
    check("rst_diff", 64'(o1_diff), 64'(0));
    check("rst_bout", 64'(o1_bout), 64'(0));
    check("rst_ready8", 64'(o8_ready), 64'(1));
    rst = 1'b0;

    // First edge after reset release accepts
    op1(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1); wait1();
    op1(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1); wait1();
    op1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1); wait1();

    // Start during RUN is ignored and the previous result stays on diff
    op1(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    s1_a = 32'h0000_0009; s1_b = 32'h0000_0001; s1_bin = 1'b0; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    check("run_busy", 64'(o1_busy), 64'(1));
    check("run_ready", 64'(o1_ready), 64'(0));
    check("run_diff_hold", 64'(o1_diff), 64'(32'hFFFF_FFFF));
    repeat (40) @(posedge clk);
    #1;

    op1(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1); wait1();

    // Reset 16 cycles into RUN aborts without a done pulse
    op1(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(o1_ready), 64'(1));
    check("abort_busy", 64'(o1_busy), 64'(0));
    check("abort_done", 64'(o1_done), 64'(0));
    check("abort_diff", 64'(o1_diff), 64'(0));
    check("abort_bout", 64'(o1_bout), 64'(0));
`ifdef SUB32_OVF_EN
    check("abort_ovf", 64'(o1_ovf), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    op1(32'h0000_000A, 32'h0000_0004, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b1); wait1();

    // DIGIT_W=8: start held high gives back-to-back ops, done every 5th cycle
    s8_a = 32'h0000_0010; s8_b = 32'h0000_0001; s8_bin = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1;
    push8(32'h0000_000F, 1'b0, 1'b0);
    s8_a = 32'h0000_0003; s8_b = 32'h0000_0004;
    repeat (5) @(posedge clk);
    #1;
    push8(32'hFFFF_FFFF, 1'b1, 1'b0);
    s8_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, ~rb} + 33'(!rbin);
      md = sum[31:0];
      s8_a = ra; s8_b = rb; s8_bin = rbin; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      push8(md, ~sum[32], (ra[31] != rb[31]) && (md[31] != ra[31]));
      repeat (5) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    if (q1.size() != 0) begin
      total++; bad++;
      $display("FAIL u1_missing_done: got %0d pending expected 0", q1.size());
    end
    if (q8.size() != 0) begin
      total++; bad++;
      $display("FAIL u8_missing_done: got %0d pending expected 0", q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub32_seq.md
SUB32_SEQ -- requirements
Module: sub32_seq

Interface
REQ-001 Parameter: DIGIT_W, default 1, bits processed per RUN cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled on a clk edge while ready=1.
REQ-005 a  input  32  minuend; latched when start is accepted.
REQ-006 b  input  32  subtrahend; latched when start is accepted.
REQ-007 bin  input  1  borrow-in; latched when start is accepted.
REQ-008 ready  output  1  high in IDLE and DONE; start is accepted only when high.
REQ-009 busy  output  1  high in RUN only.
REQ-010 done  output  1  one-cycle pulse, high in DONE only.
REQ-011 diff  output  32  registered difference, LSB-first digit-serial result.
REQ-012 bout  output  1  registered borrow-out.
REQ-013 ovf  output  1  signed overflow; present only under SUB32_OVF_EN.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; N = 32/DIGIT_W digit cycles.
REQ-015 IDLE or DONE with start=1 at edge k -> latch a, b, bin; clear digit counter; enter RUN.
REQ-016 IDLE with start=0 -> stay IDLE; DONE with start=0 -> IDLE at next edge.
REQ-017 Each RUN edge SHALL subtract one DIGIT_W-bit digit, LSB first, with the borrow chained from the previous digit (initial borrow = bin).
REQ-018 At edge k+N, diff/bout (and ovf) SHALL update and state SHALL enter DONE; done=1 for exactly the following cycle.
REQ-019 Start-to-done latency SHALL be N edges; DIGIT_W=1 gives 32, DIGIT_W=32 gives 1.
REQ-020 Result SHALL satisfy {bout,diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^33; bout=1 iff a < b + bin (unsigned).
REQ-021 start during RUN SHALL be ignored: no operand change, no extra done.
REQ-022 Operand inputs SHALL be don't-care outside the accepting edge.
REQ-023 diff/bout/ovf SHALL hold the last result until the next DONE entry; intermediate digits SHALL NOT be visible on diff.
REQ-024 start accepted in the DONE cycle SHALL start the next operation with no idle gap (back-to-back).

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, counter 0, diff=0, bout=0, ovf=0, done=0, busy=0, ready=1.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-027 The first edge after rst falls SHALL be able to accept start.

Configuration
REQ-028 Macro SUB32_OVF_EN defined: port ovf exists, updated at DONE entry as (a[31]!=b[31]) && (diff[31]!=a[31]) using latched operands, cleared by reset.
REQ-029 Macro SUB32_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 DIGIT_W=1, a=0, b=0, bin=0 -> done 32 edges after accept, diff=00000000, bout=0.
REQ-031 a=00000000, b=00000001, bin=0 -> diff=FFFFFFFF, bout=1; a=FFFFFFFF, b=FFFFFFFF, bin=1 -> diff=FFFFFFFF, bout=1.
REQ-032 SUB32_OVF_EN, a=80000000, b=00000001, bin=0 -> diff=7FFFFFFF, bout=0, ovf=1; a=00000005, b=00000003 -> diff=00000002, ovf=0.
REQ-033 Start 00000005-00000003, then start=1 with 00000009-00000001 ten cycles later (RUN) -> single done, diff=00000002.
REQ-034 rst pulsed 16 cycles into RUN -> all outputs at reset values, no done; next op 0000000A-00000004 -> diff=00000006.
REQ-035 DIGIT_W=8, start held high with 00000010-00000001 then 00000003-00000004 -> done every 5th cycle (4 RUN + DONE), diff=0000000F/bout=0, then FFFFFFFF/bout=1; plus 20 random vectors compared against a+(~b)+!bin.
